axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
- Synthesizable AXI4-Lite master: the initiator counterpart to the S00_AXI register slave of the VGA IP.
- Takes single-beat write or read commands over a simple valid/ready command port, runs the AXI4-Lite transaction, and returns the response on a one-cycle result strobe.
- Used on-chip to program the VGA register slave (e.g. from the PS/2 command decoder).
- Also used as a synthesizable stimulus master in the block-design bench.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address bus width.
- C_M_AXI_DATA_WIDTH, 32, data bus width; 32 only.
- C_TIMEOUT_CYCLES, 256, cycles from command acceptance after which the timeout flag sets.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- rsp_timeout  out  1  transaction exceeded C_TIMEOUT_CYCLES.
- busy  out  1  a transaction is in flight.
- M_AXI_AWADDR  out  ADDR_WIDTH.
- M_AXI_AWPROT  out  3.
- M_AXI_AWVALID  out  1.
- M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  DATA_WIDTH.
- M_AXI_WSTRB  out  DATA_WIDTH/8.
- M_AXI_WVALID  out  1.
- M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2.
- M_AXI_BVALID  in  1.
- M_AXI_BREADY  out  1.
- M_AXI_ARADDR  out  ADDR_WIDTH.
- M_AXI_ARPROT  out  3.
- M_AXI_ARVALID  out  1.
- M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  DATA_WIDTH.
- M_AXI_RRESP  in  2.
- M_AXI_RVALID  in  1.
- M_AXI_RREADY  out  1.

Behaviour:
- Reset (ARESET=1 at a rising edge): state IDLE; all VALID/READY outputs 0; cmd_ready 1; rsp_valid 0; rsp_rdata 0; rsp_resp 0; rsp_timeout 0; busy 0; address/data registers 0.
- Reset asserted mid-transaction: same result at that edge. The in-flight transaction is abandoned and no rsp_valid is issued.
- AWPROT and ARPROT are constant 3'b000.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, wdata, wstrb and direction.
  - If cmd_write: go to WR_ADDR_DATA with AWVALID=1 and WVALID=1 from the next cycle.
  - If read: go to RD_ADDR with ARVALID=1 from the next cycle.
  - cmd_ready is 0 in every other state.
- WR_ADDR_DATA:
  - AW and W handshakes complete independently, in either order or the same cycle.
  - Each VALID stays high until its own READY is sampled high, then drops the next cycle.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP:
  - BREADY=1.
  - On BVALID, capture BRESP and go to DONE.
  - BREADY is never 1 outside WR_RESP.
- RD_ADDR: ARVALID held until ARREADY, then go to RD_DATA.
- RD_DATA:
  - RREADY=1.
  - On RVALID, capture RDATA and RRESP, then go to DONE.
- DONE: rsp_valid=1 for exactly one cycle with the captured values, then IDLE. There is no backpressure on rsp.
- rsp_rdata holds its last value until the next DONE. Writes load 0.
- A VALID is never dropped before its handshake (AXI rule), including when a timeout occurs.
- Timeout counter:
  - Clears on command acceptance and increments each busy cycle, saturating.
  - When it reaches C_TIMEOUT_CYCLES, rsp_timeout sets and stays set until the next command acceptance.
  - The transaction keeps waiting; the timeout does not abort it.
- busy = (state != IDLE).
- Minimum latency with AWREADY/WREADY/ARREADY tied high and BVALID/RVALID returned on the cycle after the address handshake:
  - Accept at cycle 0, address handshake at cycle 1, response at cycle 2, rsp_valid at cycle 3.
  - cmd_ready returns at cycle 4.
  - Back-to-back command throughput is therefore one command every 4 cycles minimum.
- If cmd_valid is held high continuously, the next command is accepted on the first IDLE cycle.

Test Plan:
- Write/readback against the VGA S00_AXI slave:
  - Write 0x0101FFFF to offset 0x0, then read 0x0 → rsp_resp=00, rsp_rdata=0x0101FFFF.
  - Repeat for offsets 0x4, 0x8, 0xC with 0xabcd0001, 0xdead0011, 0xbeef0011 → each readback matches.
- Skewed write channels: AWREADY delayed 3 cycles, WREADY immediate.
  - WVALID drops after 1 cycle; AWVALID is held 4 cycles.
  - Exactly one BREADY window; one rsp_valid.
- Same test with WREADY delayed and AWREADY immediate → mirror behaviour.
- Error responses:
  - Slave returns BRESP=2'b10 → rsp_resp=10.
  - Read returns RRESP=2'b11 with RDATA=0x12345678 → rsp_resp=11, rsp_rdata=0x12345678.
- Timeout: C_TIMEOUT_CYCLES=16, slave never asserts ARREADY.
  - rsp_timeout rises 16 cycles after acceptance.
  - ARVALID stays 1 and busy stays 1.
  - Releasing ARREADY then RVALID completes with rsp_valid=1 and rsp_timeout still 1.
  - The next command acceptance clears rsp_timeout.
- Reset mid-operation: assert ARESET in WR_RESP → next edge all VALID/READY=0, cmd_ready=1, no rsp_valid; a following read completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite single-beat master: accepts write/read commands on a valid/ready
// port, runs the bus transaction and returns the response on a one-cycle strobe.
module axi_lite_cmd_master #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_TIMEOUT_CYCLES   = 256
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   // command / response port
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              rsp_timeout,
   output logic                              busy,
   // write address channel
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   // write data channel
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   // write response channel
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   // read address channel
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   // read data channel
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
   localparam int unsigned SW    = DW / 8;
   localparam int unsigned CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(C_TIMEOUT_CYCLES);

   localparam logic [2:0] ST_IDLE         = 3'd0;
   localparam logic [2:0] ST_WR_ADDR_DATA = 3'd1;
   localparam logic [2:0] ST_WR_RESP      = 3'd2;
   localparam logic [2:0] ST_RD_ADDR      = 3'd3;
   localparam logic [2:0] ST_RD_DATA      = 3'd4;
   localparam logic [2:0] ST_DONE         = 3'd5;

   logic [2:0]       state_q,       state_d;
   logic [AW-1:0]    addr_q,        addr_d;
   logic [DW-1:0]    wdata_q,       wdata_d;
   logic [SW-1:0]    wstrb_q,       wstrb_d;
   logic             awvalid_q,     awvalid_d;
   logic             wvalid_q,      wvalid_d;
   logic             bready_q,      bready_d;
   logic             arvalid_q,     arvalid_d;
   logic             rready_q,      rready_d;
   logic             cmd_ready_q,   cmd_ready_d;
   logic             busy_q,        busy_d;
   logic             rsp_valid_q,   rsp_valid_d;
   logic [DW-1:0]    rsp_rdata_q,   rsp_rdata_d;
   logic [1:0]       rsp_resp_q,    rsp_resp_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0] to_cnt_q,      to_cnt_d;
   logic             accept;
   logic             aw_hs;
   logic             w_hs;

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      to_cnt_d      = to_cnt_q;
      accept        = 1'b0;
      aw_hs         = awvalid_q & M_AXI_AWREADY;
      w_hs          = wvalid_q & M_AXI_WREADY;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               accept  = 1'b1;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               if (cmd_write) begin
                  state_d   = ST_WR_ADDR_DATA;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = ST_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end

         // A channel whose VALID is already low has completed its handshake
         ST_WR_ADDR_DATA: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
               state_d  = ST_WR_RESP;
               bready_d = 1'b1;
            end
         end

         ST_WR_RESP: begin
            if (M_AXI_BVALID) begin
               rsp_resp_d  = M_AXI_BRESP;
               rsp_rdata_d = '0;
               bready_d    = 1'b0;
               state_d     = ST_DONE;
            end
         end

         ST_RD_ADDR: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_DATA;
            end
         end

         ST_RD_DATA: begin
            if (M_AXI_RVALID) begin
               rsp_rdata_d = M_AXI_RDATA;
               rsp_resp_d  = M_AXI_RRESP;
               rready_d    = 1'b0;
               state_d     = ST_DONE;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      rsp_valid_d = (state_d == ST_DONE);

      // Timeout only flags a slow slave; the transaction keeps waiting
      if (accept) begin
         to_cnt_d      = '0;
         rsp_timeout_d = 1'b0;
      end else if ((state_q != ST_IDLE) && (to_cnt_q < TO_LIMIT)) begin
         to_cnt_d = to_cnt_q + CNT_W'(1);
         if (to_cnt_d == TO_LIMIT) rsp_timeout_d = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         cmd_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
         to_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         cmd_ready_q   <= cmd_ready_d;
         busy_q        <= busy_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
         to_cnt_q      <= to_cnt_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign busy          = busy_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_timeout   = rsp_timeout_q;

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a table of directed transactions against a
// four-register slave model, plus hand-written reset sequences.
module tb_axi_lite_cmd_master;

   localparam int unsigned TO     = 16;
   localparam int          BUDGET = 60;
   localparam int          NVEC   = 19;

   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          awd, wd, bd, ard, rd;
      logic [1:0]  bresp, rresp;
      bit          force_r;
      logic [31:0] frdata;
      logic [1:0]  e_resp;
      logic [31:0] e_rdata;
      bit          e_to;
      int          e_lat, e_awc, e_wc, e_bc, e_arc, e_rc, e_tofirst;
   } vec_t;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout, busy;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] mem [4];
   vec_t        tbl [NVEC];

   axi_lite_cmd_master #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .C_TIMEOUT_CYCLES   (TO)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_wstrb     (cmd_wstrb),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .rsp_timeout   (rsp_timeout),
      .busy          (busy),
      .M_AXI_AWADDR  (M_AXI_AWADDR),
      .M_AXI_AWPROT  (M_AXI_AWPROT),
      .M_AXI_AWVALID (M_AXI_AWVALID),
      .M_AXI_AWREADY (M_AXI_AWREADY),
      .M_AXI_WDATA   (M_AXI_WDATA),
      .M_AXI_WSTRB   (M_AXI_WSTRB),
      .M_AXI_WVALID  (M_AXI_WVALID),
      .M_AXI_WREADY  (M_AXI_WREADY),
      .M_AXI_BRESP   (M_AXI_BRESP),
      .M_AXI_BVALID  (M_AXI_BVALID),
      .M_AXI_BREADY  (M_AXI_BREADY),
      .M_AXI_ARADDR  (M_AXI_ARADDR),
      .M_AXI_ARPROT  (M_AXI_ARPROT),
      .M_AXI_ARVALID (M_AXI_ARVALID),
      .M_AXI_ARREADY (M_AXI_ARREADY),
      .M_AXI_RDATA   (M_AXI_RDATA),
      .M_AXI_RRESP   (M_AXI_RRESP),
      .M_AXI_RVALID  (M_AXI_RVALID),
      .M_AXI_RREADY  (M_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
      end
   endtask

   task automatic slave_idle();
      M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY  = 1'b0;
      M_AXI_BVALID  = 1'b0;
      M_AXI_BRESP   = 2'b00;
      M_AXI_ARREADY = 1'b0;
      M_AXI_RVALID  = 1'b0;
      M_AXI_RDATA   = '0;
      M_AXI_RRESP   = 2'b00;
   endtask

   function automatic vec_t vw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      vec_t v;
      v = '{write: 1'b1, addr: a, wdata: d, strb: s, awd: 0, wd: 0, bd: 0, ard: 0, rd: 0,
            bresp: 2'b00, rresp: 2'b00, force_r: 1'b0, frdata: '0, e_resp: 2'b00, e_rdata: '0,
            e_to: 1'b0, e_lat: 3, e_awc: 1, e_wc: 1, e_bc: 1, e_arc: 0, e_rc: 0, e_tofirst: 0};
      return v;
   endfunction

   function automatic vec_t vr(input logic [31:0] a, input logic [31:0] exp_d);
      vec_t v;
      v = '{write: 1'b0, addr: a, wdata: '0, strb: 4'h0, awd: 0, wd: 0, bd: 0, ard: 0, rd: 0,
            bresp: 2'b00, rresp: 2'b00, force_r: 1'b0, frdata: '0, e_resp: 2'b00, e_rdata: exp_d,
            e_to: 1'b0, e_lat: 3, e_awc: 0, e_wc: 0, e_bc: 0, e_arc: 1, e_rc: 1, e_tofirst: 0};
      return v;
   endfunction

   // Issue one command and act as the slave, cycle by cycle, until the response
   task automatic run_txn(input vec_t v, input string nm);
      int   c = 0, lat = 0, to_first = 0;
      int   awc = 0, wc = 0, bc = 0, arc = 0, rc = 0;
      int   aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
      int   viol = 0, bad_bus = 0, bad_state = 0;
      bit   got = 1'b0;
      logic [31:0] g_rdata = '0;
      logic [1:0]  g_resp = '0;
      logic        g_to = 1'b0;
      logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;

      @(negedge ACLK);
      chk({nm, " cmd_ready before"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_wstrb = v.strb;
      while (!got && c < BUDGET) begin
         @(negedge ACLK);
         c++;
         cmd_valid = 1'b0;
         if ((p_awv && !p_awr && !M_AXI_AWVALID) || (p_wv && !p_wr && !M_AXI_WVALID) ||
             (p_arv && !p_arr && !M_AXI_ARVALID)) viol++;
         if ((M_AXI_AWVALID && M_AXI_AWADDR !== v.addr) ||
             (M_AXI_WVALID && (M_AXI_WDATA !== v.wdata || M_AXI_WSTRB !== v.strb)) ||
             (M_AXI_ARVALID && M_AXI_ARADDR !== v.addr) ||
             M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) bad_bus++;
         if (busy !== 1'b1 || cmd_ready !== 1'b0) bad_state++;
         if (rsp_timeout === 1'b1 && to_first == 0) to_first = c;
         if (rsp_valid === 1'b1) begin
            got     = 1'b1;
            lat     = c;
            g_rdata = rsp_rdata;
            g_resp  = rsp_resp;
            g_to    = rsp_timeout;
         end
         M_AXI_AWREADY = M_AXI_AWVALID && (aw_n >= v.awd);
         if (M_AXI_AWVALID) begin awc++; aw_n++; end
         M_AXI_WREADY = M_AXI_WVALID && (w_n >= v.wd);
         if (M_AXI_WVALID) begin wc++; w_n++; end
         M_AXI_ARREADY = M_AXI_ARVALID && (ar_n >= v.ard);
         if (M_AXI_ARVALID) begin arc++; ar_n++; end
         M_AXI_BRESP  = v.bresp;
         M_AXI_BVALID = M_AXI_BREADY && (b_n >= v.bd);
         if (M_AXI_BREADY) begin bc++; b_n++; end
         if (M_AXI_BVALID && v.bresp == 2'b00)
            for (int b = 0; b < 4; b++)
               if (v.strb[b]) mem[v.addr[3:2]][8*b +: 8] = v.wdata[8*b +: 8];
         M_AXI_RRESP  = v.rresp;
         M_AXI_RDATA  = v.force_r ? v.frdata : mem[v.addr[3:2]];
         M_AXI_RVALID = M_AXI_RREADY && (r_n >= v.rd);
         if (M_AXI_RREADY) begin rc++; r_n++; end
         p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY;
         p_wv  = M_AXI_WVALID;  p_wr  = M_AXI_WREADY;
         p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY;
      end
      chk({nm, " completed"}, 32'(got), 32'd1);
      slave_idle();
      @(negedge ACLK);
      chk({nm, " {rsp_valid,busy,cmd_ready} after"}, 32'({rsp_valid, busy, cmd_ready}), 32'b001);
      chk({nm, " rsp_resp"},     32'(g_resp),    32'(v.e_resp));
      chk({nm, " rsp_rdata"},    g_rdata,        v.e_rdata);
      chk({nm, " rsp_timeout"},  32'(g_to),      32'(v.e_to));
      chk({nm, " latency"},      32'(lat),       32'(v.e_lat));
      chk({nm, " awvalid cyc"},  32'(awc),       32'(v.e_awc));
      chk({nm, " wvalid cyc"},   32'(wc),        32'(v.e_wc));
      chk({nm, " bready cyc"},   32'(bc),        32'(v.e_bc));
      chk({nm, " arvalid cyc"},  32'(arc),       32'(v.e_arc));
      chk({nm, " rready cyc"},   32'(rc),        32'(v.e_rc));
      chk({nm, " valid drop"},   32'(viol),      32'd0);
      chk({nm, " bus fields"},   32'(bad_bus),   32'd0);
      chk({nm, " busy/ready"},   32'(bad_state), 32'd0);
      chk({nm, " timeout cyc"},  32'(to_first),  32'(v.e_tofirst));
   endtask

   initial begin
      int c;
      int rsp_seen;
      // Directed transaction table with hand-computed expectations
      tbl[0]  = vw(32'h0, 32'h0101FFFF, 4'hF);
      tbl[1]  = vr(32'h0, 32'h0101FFFF);
      tbl[2]  = vw(32'h4, 32'hABCD0001, 4'hF);
      tbl[3]  = vr(32'h4, 32'hABCD0001);
      tbl[4]  = vw(32'h8, 32'hDEAD0011, 4'hF);
      tbl[5]  = vr(32'h8, 32'hDEAD0011);
      tbl[6]  = vw(32'hC, 32'hBEEF0011, 4'hF);
      tbl[7]  = vr(32'hC, 32'hBEEF0011);
      tbl[8]  = vw(32'h8, 32'h11112222, 4'hF);
      tbl[8].awd = 3;  tbl[8].e_lat = 6;  tbl[8].e_awc = 4;
      tbl[9]  = vw(32'hC, 32'h33334444, 4'hF);
      tbl[9].wd = 3;   tbl[9].e_lat = 6;  tbl[9].e_wc = 4;
      tbl[10] = vw(32'h0, 32'h55555555, 4'hF);
      tbl[10].bresp = 2'b10; tbl[10].e_resp = 2'b10;
      tbl[11] = vr(32'h4, 32'h12345678);
      tbl[11].rresp = 2'b11; tbl[11].force_r = 1'b1; tbl[11].frdata = 32'h12345678;
      tbl[11].e_resp = 2'b11;
      tbl[12] = vr(32'h0, 32'h0101FFFF);
      tbl[13] = vw(32'h8, 32'hAABBCCDD, 4'b0101);
      tbl[14] = vr(32'h8, 32'h11BB22DD);
      tbl[15] = vr(32'hC, 32'h33334444);
      tbl[15].ard = 2; tbl[15].rd = 2; tbl[15].e_lat = 7; tbl[15].e_arc = 3; tbl[15].e_rc = 3;
      tbl[16] = vw(32'h4, 32'h0F0F0F0F, 4'hF);
      tbl[16].bd = 1;  tbl[16].e_lat = 4; tbl[16].e_bc = 2;
      tbl[17] = vr(32'h4, 32'h0F0F0F0F);
      tbl[17].ard = 24; tbl[17].e_lat = 27; tbl[17].e_arc = 25;
      tbl[17].e_to = 1'b1; tbl[17].e_tofirst = 17;
      tbl[18] = vr(32'h0, 32'h0101FFFF);

      for (int i = 0; i < 4; i++) mem[i] = '0;
      ARESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_wstrb = '0;
      slave_idle();
      repeat (3) @(negedge ACLK);
      chk("reset valid/ready", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                    M_AXI_RREADY, rsp_valid, busy, cmd_ready}), 32'b0000_0001);
      chk("reset rsp fields", 32'({rsp_resp, rsp_timeout}), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset addr/data", M_AXI_AWADDR | M_AXI_ARADDR | M_AXI_WDATA | 32'(M_AXI_WSTRB), 32'd0);
      ARESET = 1'b0;

      for (int i = 0; i < NVEC; i++) run_txn(tbl[i], $sformatf("v%0d", i));

      // Reset while waiting in WR_RESP abandons the write without a response
      @(negedge ACLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h8;
      cmd_wdata = 32'hCAFEF00D;
      cmd_wstrb = 4'hF;
      c = 0;
      while (M_AXI_BREADY !== 1'b1 && c < 10) begin
         @(negedge ACLK);
         c++;
         cmd_valid     = 1'b0;
         M_AXI_AWREADY = M_AXI_AWVALID;
         M_AXI_WREADY  = M_AXI_WVALID;
      end
      chk("rst_mid reached WR_RESP", 32'(M_AXI_BREADY), 32'd1);
      slave_idle();
      ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      chk("rst_mid valid/ready", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                      M_AXI_RREADY, rsp_valid, busy, cmd_ready}), 32'b0000_0001);
      chk("rst_mid rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_mid addr/data", M_AXI_AWADDR | M_AXI_WDATA, 32'd0);
      rsp_seen = 0;
      repeat (4) begin
         @(negedge ACLK);
         if (rsp_valid !== 1'b0) rsp_seen++;
      end
      chk("rst_mid no rsp_valid", 32'(rsp_seen), 32'd0);
      run_txn(vr(32'h8, 32'h11BB22DD), "post_reset_read");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
